uart_tx_queue: RTL and testbench
================================

// Module: uart_tx_queue
// PURPOSE
// - Byte FIFO plus launch FSM that sits directly upstream of the UART transmitter in uart_top.
// - Absorbs bursts of bytes from the host side.
// - Feeds the transmitter one byte per frame over its tx_data / tx_send / tx_busy handshake.
// - Host never has to poll tx_busy.
// PARAMETERS
// - DATA_W  8   byte width; must match the transmitter tx_data width
// - DEPTH   16  FIFO entries; power of two, >= 2
// - AW      4   pointer width; must equal log2(DEPTH)
// PORTS
// - clk      in   1         system clock
// - reset    in   1         synchronous, active-high reset
// - wr_en    in   1         host write strobe; one byte per cycle
// - wr_data  in   DATA_W    host byte
// - full     out  1         count == DEPTH
// - empty    out  1         count == 0
// - count    out  AW+1      bytes stored, 0..DEPTH
// - tx_data  out  DATA_W    byte to transmitter; held stable from launch until tx_busy rises
// - tx_send  out  1         one-cycle launch pulse to transmitter
// - tx_busy  in   1         transmitter busy flag
// - overflow out  1         sticky drop flag; present only with UART_TXQ_OVERFLOW_EN
// BEHAVIOUR
// - One clock: clk. Reset is synchronous and active-high on `reset`.
// - Reset values: count=0, empty=1, full=0, tx_send=0, tx_data=0, overflow=0. Pointers=0; FSM=IDLE.
// - Write: accepted at a clk edge iff wr_en && !full, using registered full from before the edge. Otherwise dropped silently.
// - No write-through when full, even if a pop happens in the same cycle.
// - Pop: occurs only in IDLE when !empty && !tx_busy.
// - Simultaneous accepted write + pop: count unchanged. Both pointers advance.
// - Pointer wrap: pointers wrap modulo DEPTH. full/empty come from count, never from pointer compare.
// - FSM state IDLE: if !empty && !tx_busy, then:
//   - pop the head byte into tx_data;
//   - register tx_send=1 for exactly one cycle;
//   - go to WAIT_BUSY.
// - FSM state WAIT_BUSY: tx_send=0; tx_data held. On tx_busy=1, go to WAIT_DONE. Waits indefinitely; no timeout.
// - FSM state WAIT_DONE: on tx_busy=0, go to IDLE. Next launch is no earlier than the cycle after returning to IDLE.
// - Latency: write at edge N into an empty queue with the transmitter idle gives tx_send high in cycle N+1..N+2 (edge N+1 asserts it).
// - Write into empty queue same cycle as IDLE check: the byte is not visible until the next cycle (no bypass).
// - Reset mid-frame:
//   - FIFO contents are discarded; FSM returns to IDLE; tx_send=0.
//   - A frame already in the transmitter is its own concern.
// - tx_send is never high for two consecutive cycles.
// - tx_send never asserts while tx_busy=1.
// CONFIGURATION
// - UART_TXQ_OVERFLOW_EN defined:
//   - overflow port exists.
//   - Set to 1 on the edge where wr_en && full.
//   - Stays 1 until reset.
// - UART_TXQ_OVERFLOW_EN undefined:
//   - overflow port and logic are absent.
//   - Dropped writes are invisible; all other behaviour is identical.
// TESTING
// - Bench setup: uart_top loopback, clk 1 MHz, baud 9600 (about 1042 clk per frame), unless stated standalone.
// - T1 reset: hold reset 5 cycles -> empty=1, full=0, count=0, tx_send=0, tx_data=0x00, overflow=0.
// - T2 single byte: write 0x55 ->
//   - tx_send is a single 1-cycle pulse one cycle after the write;
//   - tx_data=0x55 until tx_busy rises;
//   - rx_data=0x55 on rx_ready.
// - T3 burst: write 0x00, 0xFF, 0xAA, 0x55 on 4 consecutive cycles ->
//   - count peaks at 3;
//   - exactly 4 tx_send pulses, each after the previous tx_busy fall;
//   - rx sequence 0x00, 0xFF, 0xAA, 0x55.
// - T4 fill (standalone, tx_busy forced 1): write 17 bytes 0x01..0x11 ->
//   - full=1 and count=16 after the 16th write;
//   - 17th dropped; overflow=1 with macro;
//   - release tx_busy: bytes emerge 0x01..0x10.
// - T5 simultaneous: count=3, transmitter idle, wr_en on the pop cycle -> count stays 3; FIFO order preserved.
// - T6 reset in WAIT_DONE with 2 bytes queued -> next cycle count=0, empty=1; no tx_send after tx_busy falls.

Source files
------------

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_queue
// Description : Byte FIFO with a launch FSM that feeds a UART transmitter over
//               a tx_data / tx_send / tx_busy handshake. Defining
//               UART_TXQ_OVERFLOW_EN adds a sticky overflow (dropped write) flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_send,
    input  logic              tx_busy
`ifdef UART_TXQ_OVERFLOW_EN
    ,
    output logic              overflow
`endif
);

    localparam logic [AW:0]   c_FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE    = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic [DATA_W-1:0]  r_tx_data;
    logic               r_tx_send;
    logic               w_full;
    logic               w_empty;
    logic               w_wr_accept;
    logic               w_pop;

    // Flags derive from the count so pointer equality is never ambiguous.
    assign w_full      = (r_count == c_FULL_COUNT);
    assign w_empty     = (r_count == '0);
    assign w_wr_accept = wr_en && !w_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty && !tx_busy) begin
                    w_pop        = 1'b1;
                    w_state_next = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_tx_data <= '0;
            r_tx_send <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
                r_tx_data <= r_mem[r_rd_ptr];
            end
            case ({w_wr_accept, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_tx_send <= w_pop;
        end
    end

`ifdef UART_TXQ_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (wr_en && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`endif

    assign full    = w_full;
    assign empty   = w_empty;
    assign count   = r_count;
    assign tx_data = r_tx_data;
    assign tx_send = r_tx_send;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_queue
// Description : Standalone directed bench for uart_tx_queue with a simple
//               transmitter model that holds tx_busy for a short frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_queue;

    localparam int c_FRAME = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy;
`ifdef UART_TXQ_OVERFLOW_EN
    logic        overflow;
`endif

    logic        force_busy = 1'b0;
    logic        model_busy = 1'b0;
    int          model_cnt  = 0;
    logic        prev_send  = 1'b0;
    int          n_sends    = 0;
    int          n_viol     = 0;
    logic [7:0]  rx_q [$];

    int          n_checks = 0;
    int          n_errors = 0;

    assign tx_busy = force_busy | model_busy;

    uart_tx_queue #(.DATA_W(8), .DEPTH(16), .AW(4)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .tx_data (tx_data),
        .tx_send (tx_send),
        .tx_busy (tx_busy)
`ifdef UART_TXQ_OVERFLOW_EN
        ,
        .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    // Transmitter model plus protocol watchdog on the launch pulse.
    always @(posedge clk) begin
        if (tx_send) begin
            n_sends++;
            rx_q.push_back(tx_data);
            if (tx_busy)   n_viol++;
            if (prev_send) n_viol++;
        end
        prev_send = tx_send;
        if (tx_send && !model_busy) begin
            model_busy <= 1'b1;
            model_cnt  <= c_FRAME;
        end else if (model_busy) begin
            if (model_cnt == 0) model_busy <= 1'b0;
            else                model_cnt  <= model_cnt - 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 3000 && !(rx_q.size() >= n && !tx_busy); i++) tick();
        tick(); tick(); tick();
        check_val("rx_count", rx_q.size(), n);
    endtask

    int          peak;
    int          sends_before;
    logic [7:0]  exp_b;
    logic [7:0]  burst [4];

    initial begin
        burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'hAA; burst[3] = 8'h55;

        // T1 reset
        reset = 1'b1;
        repeat (5) tick();
        check_val("rst_empty",   empty,   1);
        check_val("rst_full",    full,    0);
        check_val("rst_count",   count,   0);
        check_val("rst_tx_send", tx_send, 0);
        check_val("rst_tx_data", tx_data, 8'h00);
`ifdef UART_TXQ_OVERFLOW_EN
        check_val("rst_overflow", overflow, 0);
`endif
        reset = 1'b0;
        tick();

        // T2 single byte
        rx_q.delete();
        write_byte(8'h55);
        check_val("t2_count_after_wr", count, 1);
        check_val("t2_no_send_yet",    tx_send, 0);
        tick();
        check_val("t2_send_pulse", tx_send, 1);
        check_val("t2_tx_data",    tx_data, 8'h55);
        check_val("t2_empty",      empty,   1);
        tick();
        check_val("t2_send_single", tx_send, 0);
        check_val("t2_data_held",   tx_data, 8'h55);
        wait_rx(1);
        check_val("t2_rx0", rx_q[0], 8'h55);

        // T3 burst of four
        rx_q.delete();
        peak = 0;
        for (int i = 0; i < 4; i++) begin
            write_byte(burst[i]);
            if (int'(count) > peak) peak = int'(count);
        end
        check_val("t3_peak_count", peak, 3);
        wait_rx(4);
        for (int i = 0; i < 4; i++) check_val("t3_rx_order", rx_q[i], burst[i]);

        // T4 fill with transmitter held busy
        rx_q.delete();
        force_busy = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            write_byte(8'(i));
            if (i == 15) begin
                check_val("t4_full_at15",  full,  0);
                check_val("t4_count_at15", count, 15);
            end
            if (i == 16) begin
                check_val("t4_full_at16",  full,  1);
                check_val("t4_count_at16", count, 16);
            end
        end
        check_val("t4_count_after17", count, 16);
        check_val("t4_no_launch",     n_sends - 0 >= 0 ? rx_q.size() : 0, 0);
`ifdef UART_TXQ_OVERFLOW_EN
        check_val("t4_overflow", overflow, 1);
`endif
        force_busy = 1'b0;
        wait_rx(16);
        for (int i = 0; i < 16; i++) begin
            exp_b = 8'(i + 1);
            check_val("t4_rx_order", rx_q[i], exp_b);
        end
        check_val("t4_drained", empty, 1);

        // T5 write on the pop cycle
        rx_q.delete();
        force_busy = 1'b1;
        write_byte(8'hA1);
        write_byte(8'hA2);
        write_byte(8'hA3);
        check_val("t5_count_pre", count, 3);
        force_busy = 1'b0;
        write_byte(8'hA4);
        check_val("t5_count_same", count, 3);
        check_val("t5_send",       tx_send, 1);
        check_val("t5_head",       tx_data, 8'hA1);
        wait_rx(4);
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'hA1 + 8'(i);
            check_val("t5_rx_order", rx_q[i], exp_b);
        end

        // T6 reset while the transmitter is mid-frame
        rx_q.delete();
        force_busy = 1'b1;
        write_byte(8'hB1);
        write_byte(8'hB2);
        write_byte(8'hB3);
        force_busy = 1'b0;
        tick();
        check_val("t6_count_after_pop", count, 2);
        for (int i = 0; i < 50 && !tx_busy; i++) tick();
        check_val("t6_busy_seen", tx_busy, 1);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("t6_count_rst",   count,   0);
        check_val("t6_empty_rst",   empty,   1);
        check_val("t6_send_rst",    tx_send, 0);
`ifdef UART_TXQ_OVERFLOW_EN
        check_val("t6_overflow_rst", overflow, 0);
`endif
        sends_before = n_sends;
        repeat (c_FRAME * 3) tick();
        check_val("t6_no_send_after", n_sends - sends_before, 0);
        check_val("t6_count_final",   count, 0);

        check_val("protocol_violations", n_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
